// File: rtl/parallel_row_collector_if.sv
// parallel_row_collector_if: serial word input and parallel row output handshakes.
interface parallel_row_collector_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_WIDTH  = 5
);
    localparam int CNT_W = $clog2(ROW_WIDTH + 1);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  flush;
    logic                  row_valid;
    logic [DATA_WIDTH-1:0] row_data [ROW_WIDTH];
    logic [CNT_W-1:0]      row_count;
    logic                  row_ready;
    modport master (
        output in_valid, in_data, flush, row_ready,
        input  in_ready, row_valid, row_data, row_count
    );
    modport slave (
        input  in_valid, in_data, flush, row_ready,
        output in_ready, row_valid, row_data, row_count
    );
endinterface

// File: rtl/parallel_row_collector.sv
// parallel_row_collector: assembles a serial word stream into rows of ROW_WIDTH words,
// with flush to emit a partial row early.
module parallel_row_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_WIDTH  = 5
) (
    input logic clk,
    input logic arst,
    parallel_row_collector_if.slave bus
);
    localparam int CNT_W = $clog2(ROW_WIDTH + 1);
    typedef enum logic {COLLECT, FULL} state_t;
    state_t state, state_nxt;
    logic [CNT_W-1:0] count, count_inc, row_cnt;
    logic [DATA_WIDTH-1:0] data [ROW_WIDTH];
    logic accept, to_full, hand_off;
    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= COLLECT;
        else state <= state_nxt;
    end
    always_comb begin
        accept    = bus.in_valid && state == COLLECT;
        count_inc = count + CNT_W'(accept);
        to_full   = state == COLLECT &&
                    ((accept && count == CNT_W'(ROW_WIDTH - 1)) || (bus.flush && count_inc != '0));
        hand_off  = state == FULL && bus.row_ready;
        state_nxt = to_full ? FULL : hand_off ? COLLECT : state;
    end
    assign bus.in_ready  = state == COLLECT;
    assign bus.row_valid = state == FULL;
    assign bus.row_data  = data;
    assign bus.row_count = row_cnt;
    // Clearing on hand-off guarantees the unfilled tail of a flushed row reads 0.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count   <= '0;
            row_cnt <= '0;
            for (int i = 0; i < ROW_WIDTH; i++) data[i] <= '0;
        end else begin
            if (hand_off) begin
                count   <= '0;
                row_cnt <= '0;
            end else begin
                if (accept) count <= count_inc;
                if (to_full) row_cnt <= count_inc;
            end
            for (int i = 0; i < ROW_WIDTH; i++)
                if (hand_off) data[i] <= '0;
                else if (accept && count == CNT_W'(i)) data[i] <= bus.in_data;
        end
    end
    a_excl: assert property (@(posedge clk) disable iff (arst) !(bus.in_ready && bus.row_valid));
    a_cnt:  assert property (@(posedge clk) disable iff (arst) row_cnt <= CNT_W'(ROW_WIDTH));
    for (genvar g = 0; g < ROW_WIDTH; g++) begin : g_stable
        a_stable: assert property (@(posedge clk) disable iff (arst)
            bus.row_valid && !bus.row_ready |=> $stable(data[g]));
    end
endmodule

// File: tb/tb_parallel_row_collector.sv
// tb_parallel_row_collector: directed checks of row assembly, flush, backpressure and reset.
module tb_parallel_row_collector;
    logic clk = 1'b0;
    logic arst = 1'b1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    parallel_row_collector_if #(.DATA_WIDTH(8), .ROW_WIDTH(5)) bus ();
    parallel_row_collector #(.DATA_WIDTH(8), .ROW_WIDTH(5)) dut (
        .clk (clk),
        .arst(arst),
        .bus (bus.slave)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic logic [63:0] row();
        logic [63:0] r = '0;
        for (int i = 0; i < 5; i++) r = (r << 8) | 64'(bus.row_data[i]);
        return r;
    endfunction
    task automatic send(input logic [7:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = 'x;
    endtask
    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 64'(bus.row_valid), 64'd0);
        check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_count"}, 64'(bus.row_count), 64'd0);
        check({tag, "_data"}, row(), 64'h0);
    endtask
    initial begin
        logic [63:0] held;
        bus.in_valid  = 1'b0;
        bus.in_data   = 'x;
        bus.flush     = 1'b0;
        bus.row_ready = 1'b1;
        step();
        step();
        check_idle("reset");
        arst = 1'b0;
        step();
        // Test 1: full row, consumer ready
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        check("t1_not_yet", 64'(bus.row_valid), 64'd0);
        send(8'h55);
        check("t1_valid", 64'(bus.row_valid), 64'd1);
        check("t1_in_ready", 64'(bus.in_ready), 64'd0);
        check("t1_data", row(), 64'h1122334455);
        check("t1_count", 64'(bus.row_count), 64'd5);
        step();
        check_idle("t1_after");
        // Test 2 + 6: flush alone, then flush while FULL ignored
        bus.row_ready = 1'b0;
        send(8'hA1); send(8'hA2);
        bus.flush = 1'b1;
        step();
        check("t2_valid", 64'(bus.row_valid), 64'd1);
        check("t2_data", row(), 64'hA1A2000000);
        check("t2_count", 64'(bus.row_count), 64'd2);
        step();
        bus.flush = 1'b0;
        check("t6_full_flush_valid", 64'(bus.row_valid), 64'd1);
        check("t6_full_flush_count", 64'(bus.row_count), 64'd2);
        check("t6_full_flush_data", row(), 64'hA1A2000000);
        bus.row_ready = 1'b1;
        step();
        check_idle("t2_after");
        // Test 3: flush together with an accept
        send(8'h10);
        bus.flush = 1'b1;
        send(8'h7F);
        bus.flush = 1'b0;
        check("t3_valid", 64'(bus.row_valid), 64'd1);
        check("t3_count", 64'(bus.row_count), 64'd2);
        check("t3_data", row(), 64'h107F000000);
        step();
        check_idle("t3_after");
        // Test 4: backpressure with in_valid held high
        bus.row_ready = 1'b0;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        held = row();
        check("t4_data", held, 64'h0102030405);
        for (int i = 0; i < 10; i++) step();
        check("t4_held_valid", 64'(bus.row_valid), 64'd1);
        check("t4_held_ready", 64'(bus.in_ready), 64'd0);
        check("t4_held_data", row(), 64'h0102030405);
        check("t4_held_count", 64'(bus.row_count), 64'd5);
        bus.row_ready = 1'b1;
        bus.in_data   = 8'h06;
        step();
        bus.row_ready = 1'b0;
        check("t4_bubble_ready", 64'(bus.in_ready), 64'd1);
        check("t4_bubble_data", row(), 64'h0);
        send(8'h06); send(8'h07); send(8'h08); send(8'h09); send(8'h0A);
        check("t4_next_data", row(), 64'h060708090A);
        check("t4_next_count", 64'(bus.row_count), 64'd5);
        bus.row_ready = 1'b1;
        step();
        check_idle("t4_after");
        // Test 5: reset mid-row discards the partial row
        send(8'hC1); send(8'hC2); send(8'hC3);
        arst = 1'b1;
        #1;
        check_idle("t5_in_reset");
        step();
        arst = 1'b0;
        step();
        send(8'h51); send(8'h52); send(8'h53);
        check("t5_partial_valid", 64'(bus.row_valid), 64'd0);
        send(8'h54); send(8'h55);
        check("t5_valid", 64'(bus.row_valid), 64'd1);
        check("t5_data", row(), 64'h5152535455);
        check("t5_count", 64'(bus.row_count), 64'd5);
        step();
        check_idle("t5_after");
        // Test 6: flush with empty row ignored
        bus.flush = 1'b1;
        step();
        check_idle("t6_empty_flush");
        bus.flush = 1'b0;
        step();
        check_idle("t6_empty_after");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
